// File: rtl/mips_pkg.sv
// ---------------------------------------------------------------------------
// mips_pkg
// Shared types and constants for the multi-cycle MIPS datapath blocks.
//   pcseq_state_t : state encoding of the program-counter sequencer
//   PC_STEP       : byte distance between consecutive instruction words
// ---------------------------------------------------------------------------
package mips_pkg;

  // Sequencer states: wait after reset, fetch from imem, execute, stopped
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_FETCH = 2'b01,
    ST_EXEC  = 2'b10,
    ST_HALT  = 2'b11
  } pcseq_state_t;

  localparam logic [31:0] PC_STEP = 32'd4;

endpackage

// File: rtl/pc_sequencer_if.sv
// ---------------------------------------------------------------------------
// pc_sequencer_if
// Bundles the sequencer's instruction-memory handshake, the redirect/control
// inputs from the datapath and the sequencer status outputs.
//   master : the sequencer side (drives imem_req, pc, instr, status)
//   slave  : the memory/datapath side (drives ack, data, redirect, control)
// ---------------------------------------------------------------------------
interface pc_sequencer_if;

  logic        imem_req;
  logic        imem_ack;
  logic [31:0] imem_data;
  logic        branch_taken;
  logic [31:0] branch_offset;
  logic        jump;
  logic [25:0] jump_index;
  logic        stall;
  logic        halt;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] instr;
  logic        instr_valid;
  logic        halted;
  logic [31:0] retired;

  modport master (
    input  imem_ack, imem_data, branch_taken, branch_offset,
           jump, jump_index, stall, halt,
    output imem_req, pc, pc_plus4, instr, instr_valid, halted, retired
  );

  modport slave (
    output imem_ack, imem_data, branch_taken, branch_offset,
           jump, jump_index, stall, halt,
    input  imem_req, pc, pc_plus4, instr, instr_valid, halted, retired
  );

endinterface

// File: rtl/pc_sequencer_next_pc_sel.sv
// ---------------------------------------------------------------------------
// next_pc_sel
// Combinational next-PC selection for the sequencer.
//   i_pc            : address of the current instruction
//   i_jump          : current instruction is J/JAL
//   i_jump_index    : 26-bit instruction index field
//   i_branch_taken  : branch condition is true
//   i_branch_offset : sign-extended immediate, not yet shifted
//   o_pc_plus4      : pc + 4 (sequential address, JAL link value)
//   o_next_pc       : selected address of the next instruction
// ---------------------------------------------------------------------------
module next_pc_sel
  import mips_pkg::*;
(
  input  logic [31:0] i_pc,
  input  logic        i_jump,
  input  logic [25:0] i_jump_index,
  input  logic        i_branch_taken,
  input  logic [31:0] i_branch_offset,
  output logic [31:0] o_pc_plus4,
  output logic [31:0] o_next_pc
);

  logic [31:0] w_pc_plus4;
  logic [31:0] w_offset_shifted;
  logic [31:0] w_branch_target;
  logic [31:0] w_jump_target;

  // All adders are 32-bit modulo; the word shift simply drops offset[31:30]
  assign w_pc_plus4       = i_pc + PC_STEP;
  assign w_offset_shifted = i_branch_offset << 2;
  assign w_branch_target  = w_pc_plus4 + w_offset_shifted;
  assign w_jump_target    = {w_pc_plus4[31:28], i_jump_index, 2'b00};

  // Jump outranks a taken branch, which outranks sequential flow
  always_comb begin
    o_next_pc = w_pc_plus4;
    if (i_jump) begin
      o_next_pc = w_jump_target;
    end else if (i_branch_taken) begin
      o_next_pc = w_branch_target;
    end
  end

  assign o_pc_plus4 = w_pc_plus4;

endmodule

// File: rtl/pc_sequencer.sv
// ---------------------------------------------------------------------------
// pc_sequencer
// Multi-cycle program-counter sequencer: owns the PC, runs the fetch
// request/acknowledge handshake with instruction memory, latches the fetched
// instruction, selects the next PC and counts retired instructions.
//   RESET_PC : word-aligned PC loaded on reset
//   clock    : rising-edge clock
//   reset_n  : asynchronous active-low reset
//   bus      : pc_sequencer_if.master (imem handshake, redirect/control
//              inputs, pc/instr/status outputs)
// ---------------------------------------------------------------------------
module pc_sequencer
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                  clock,
  input  logic                  reset_n,
  pc_sequencer_if.master        bus
);

  pcseq_state_t r_state;
  logic         r_armed;
  logic [31:0]  r_pc;
  logic [31:0]  r_instr;
  logic         r_imem_req;
  logic         r_instr_valid;
  logic         r_halted;
  logic [31:0]  r_retired;

  logic [31:0]  w_pc_plus4;
  logic [31:0]  w_next_pc;

  next_pc_sel u_next_pc_sel (
    .i_pc            (r_pc),
    .i_jump          (bus.jump),
    .i_jump_index    (bus.jump_index),
    .i_branch_taken  (bus.branch_taken),
    .i_branch_offset (bus.branch_offset),
    .o_pc_plus4      (w_pc_plus4),
    .o_next_pc       (w_next_pc)
  );

  // Sequencer FSM with all outputs registered. IDLE spends its first edge
  // arming (letting the reset release settle) and leaves on the second, so
  // the first fetch request appears two edges after reset_n rises. Stall
  // beats halt beats redirect in EXEC; acks and redirects in any other state
  // are ignored. retired wraps silently.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= ST_IDLE;
      r_armed       <= 1'b0;
      r_pc          <= RESET_PC;
      r_instr       <= 32'h0;
      r_imem_req    <= 1'b0;
      r_instr_valid <= 1'b0;
      r_halted      <= 1'b0;
      r_retired     <= 32'h0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (r_armed) begin
            r_state    <= ST_FETCH;
            r_imem_req <= 1'b1;
          end else begin
            r_armed    <= 1'b1;
          end
        end
        ST_FETCH: begin
          if (bus.imem_ack) begin
            r_instr       <= bus.imem_data;
            r_imem_req    <= 1'b0;
            r_instr_valid <= 1'b1;
            r_state       <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (bus.stall) begin
            r_state <= ST_EXEC;
          end else if (bus.halt) begin
            r_retired     <= r_retired + 32'd1;
            r_instr_valid <= 1'b0;
            r_halted      <= 1'b1;
            r_state       <= ST_HALT;
          end else begin
            r_pc          <= w_next_pc;
            r_retired     <= r_retired + 32'd1;
            r_instr_valid <= 1'b0;
            r_imem_req    <= 1'b1;
            r_state       <= ST_FETCH;
          end
        end
        ST_HALT: begin
          r_imem_req <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.imem_req    = r_imem_req;
  assign bus.pc          = r_pc;
  assign bus.pc_plus4    = w_pc_plus4;
  assign bus.instr       = r_instr;
  assign bus.instr_valid = r_instr_valid;
  assign bus.halted      = r_halted;
  assign bus.retired     = r_retired;

endmodule
